// File: rtl/axis_width_converter_gen.sv
// AXI4-Stream data-width converter with TDEST and a completed-packet counter.
// Elaboration picks one of three datapaths from S_WIDTH / M_WIDTH:
//   equal    : single-entry register slice
//   upsize   : R narrow beats packed into one wide word (early close on tlast)
//   downsize : one wide beat split into R narrow beats, trailing empty lanes
//              of a tlast beat are trimmed
// Ports:
//   net_clk / net_rst          clock, synchronous active-high reset
//   s_axis_*                   slave stream (S_WIDTH data, S_WIDTH/8 keep)
//   m_axis_*                   master stream (M_WIDTH data, M_WIDTH/8 keep), registered
//   pkt_count                  beats accepted downstream with tlast, wraps
module axis_width_converter_gen #(
  parameter int unsigned S_WIDTH    = 64,
  parameter int unsigned M_WIDTH    = 512,
  parameter int unsigned DEST_WIDTH = 1
) (
  input  logic                  net_clk,
  input  logic                  net_rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [S_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [M_WIDTH-1:0]    m_axis_tdata,
  output logic [M_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [31:0]           pkt_count
);

  localparam int unsigned W_MAX = (S_WIDTH > M_WIDTH) ? S_WIDTH : M_WIDTH;
  localparam int unsigned W_MIN = (S_WIDTH > M_WIDTH) ? M_WIDTH : S_WIDTH;
  localparam int unsigned R     = W_MAX / W_MIN;

  // Reject width pairs whose ratio is not a power of two in 1..64.
  if ((S_WIDTH % 8) != 0 || (M_WIDTH % 8) != 0 || (W_MAX % W_MIN) != 0 ||
      R > 64 || (R & (R - 1)) != 0) begin : g_bad_ratio
    $error("axis_width_converter_gen: unsupported S_WIDTH/M_WIDTH ratio");
  end

  logic s_fire;
  assign s_fire = s_axis_tvalid && s_axis_tready;

  // Packets delivered downstream.
  always_ff @(posedge net_clk) begin
    if (net_rst) pkt_count <= '0;
    else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_count <= pkt_count + 32'd1;
  end

  if (S_WIDTH == M_WIDTH) begin : g_equal
    assign s_axis_tready = !net_rst && (!m_axis_tvalid || m_axis_tready);

    // Register slice.
    always_ff @(posedge net_clk) begin
      if (net_rst) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_axis_tkeep  <= '0;
        m_axis_tlast  <= 1'b0;
        m_axis_tdest  <= '0;
      end else if (s_fire) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tkeep  <= s_axis_tkeep;
        m_axis_tlast  <= s_axis_tlast;
        m_axis_tdest  <= s_axis_tdest;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end

  end else if (M_WIDTH > S_WIDTH) begin : g_upsize
    localparam int unsigned SB = S_WIDTH / 8;
    localparam int unsigned IW = $clog2(R);

    logic [IW-1:0]               idx;
    logic [R-1:0][S_WIDTH-1:0]   acc_data, word_data;
    logic [R-1:0][SB-1:0]        acc_keep, word_keep;
    logic [DEST_WIDTH-1:0]       acc_dest, word_dest;
    logic                        complete;

    assign s_axis_tready = !net_rst && (!m_axis_tvalid || m_axis_tready);
    assign complete      = s_axis_tlast || (idx == IW'(R - 1));

    // Word as it would look with the current beat merged in; lanes above idx are unwritten.
    always_comb begin
      word_data = acc_data;
      word_keep = acc_keep;
      for (int unsigned l = 0; l < R; l++) begin
        if (IW'(l) == idx) begin
          word_data[l] = s_axis_tdata;
          word_keep[l] = s_axis_tkeep;
        end else if (IW'(l) > idx) begin
          word_keep[l] = '0;
        end
      end
      word_dest = (idx == '0) ? s_axis_tdest : acc_dest;
    end

    // Accumulate lanes; hand the word to the output register on completion.
    always_ff @(posedge net_clk) begin
      if (net_rst) begin
        idx           <= '0;
        acc_data      <= '0;
        acc_keep      <= '0;
        acc_dest      <= '0;
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_axis_tkeep  <= '0;
        m_axis_tlast  <= 1'b0;
        m_axis_tdest  <= '0;
      end else begin
        if (m_axis_tready) m_axis_tvalid <= 1'b0;
        if (s_fire) begin
          if (complete) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= word_data;
            m_axis_tkeep  <= word_keep;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tdest  <= word_dest;
            idx           <= '0;
          end else begin
            acc_data <= word_data;
            acc_keep <= word_keep;
            acc_dest <= word_dest;
            idx      <= idx + IW'(1);
          end
        end
      end
    end

  end else begin : g_downsize
    localparam int unsigned MB = M_WIDTH / 8;
    localparam int unsigned KW = $clog2(R);

    logic [R-1:0][M_WIDTH-1:0] s_lanes, buf_data;
    logic [R-1:0][MB-1:0]      s_keep_lanes, buf_keep;
    logic                      buf_last;
    logic [KW-1:0]             k, k_nxt, buf_fin, fin_c;

    assign s_lanes      = s_axis_tdata;
    assign s_keep_lanes = s_axis_tkeep;
    assign k_nxt        = k + KW'(1);
    // Next wide beat may enter while the final lane of the current one leaves.
    assign s_axis_tready = !net_rst && (!m_axis_tvalid || (m_axis_tready && k == buf_fin));

    // Final lane: R-1, or the highest lane with any keep bit on a tlast beat (lane 0 if none).
    always_comb begin
      fin_c = KW'(R - 1);
      if (s_axis_tlast) begin
        fin_c = '0;
        for (int unsigned l = 0; l < R; l++) begin
          if (|s_keep_lanes[l]) fin_c = KW'(l);
        end
      end
    end

    // Lane 0 goes straight to the output; later lanes come from the buffer.
    always_ff @(posedge net_clk) begin
      if (net_rst) begin
        k             <= '0;
        buf_data      <= '0;
        buf_keep      <= '0;
        buf_last      <= 1'b0;
        buf_fin       <= '0;
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_axis_tkeep  <= '0;
        m_axis_tlast  <= 1'b0;
        m_axis_tdest  <= '0;
      end else if (s_fire) begin
        buf_data      <= s_lanes;
        buf_keep      <= s_keep_lanes;
        buf_last      <= s_axis_tlast;
        buf_fin       <= fin_c;
        k             <= '0;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_lanes[0];
        m_axis_tkeep  <= s_keep_lanes[0];
        m_axis_tlast  <= s_axis_tlast && (fin_c == '0);
        m_axis_tdest  <= s_axis_tdest;
      end else if (m_axis_tvalid && m_axis_tready) begin
        if (k == buf_fin) begin
          m_axis_tvalid <= 1'b0;
        end else begin
          k            <= k_nxt;
          m_axis_tdata <= buf_data[k_nxt];
          m_axis_tkeep <= buf_keep[k_nxt];
          m_axis_tlast <= buf_last && (k_nxt == buf_fin);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_width_converter_gen.sv
// Bench for axis_width_converter_gen: upsize 64->512, downsize 512->64 and
// equal 64/64 instances driven with directed and random traffic, each checked
// against a packet-level reference model.
module tb_axis_width_converter_gen;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         dest;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int u_rm = 0, d_rm = 0, e_rm = 0;   // ready mode: 0 always, 1 random, 2 toggle

  // upsize 64 -> 512
  logic u_sv = 0, u_sr, u_sl = 0, u_sdst = 0, u_mv, u_mr = 1, u_ml, u_mdst;
  logic [63:0] u_sd = '0;  logic [7:0] u_sk = '0;
  logic [511:0] u_md;      logic [63:0] u_mk;  logic [31:0] u_cnt;
  // downsize 512 -> 64
  logic d_sv = 0, d_sr, d_sl = 0, d_sdst = 0, d_mv, d_mr = 1, d_ml, d_mdst;
  logic [511:0] d_sd = '0; logic [63:0] d_sk = '0;
  logic [63:0] d_md;       logic [7:0] d_mk;   logic [31:0] d_cnt;
  // equal 64 / 64
  logic e_sv = 0, e_sr, e_sl = 0, e_sdst = 0, e_mv, e_mr = 1, e_ml, e_mdst;
  logic [63:0] e_sd = '0;  logic [7:0] e_sk = '0;
  logic [63:0] e_md;       logic [7:0] e_mk;   logic [31:0] e_cnt;

  axis_width_converter_gen #(.S_WIDTH(64), .M_WIDTH(512), .DEST_WIDTH(1)) u_up (
    .net_clk(clk), .net_rst(rst),
    .s_axis_tvalid(u_sv), .s_axis_tready(u_sr), .s_axis_tdata(u_sd), .s_axis_tkeep(u_sk),
    .s_axis_tlast(u_sl), .s_axis_tdest(u_sdst),
    .m_axis_tvalid(u_mv), .m_axis_tready(u_mr), .m_axis_tdata(u_md), .m_axis_tkeep(u_mk),
    .m_axis_tlast(u_ml), .m_axis_tdest(u_mdst), .pkt_count(u_cnt));

  axis_width_converter_gen #(.S_WIDTH(512), .M_WIDTH(64), .DEST_WIDTH(1)) u_dn (
    .net_clk(clk), .net_rst(rst),
    .s_axis_tvalid(d_sv), .s_axis_tready(d_sr), .s_axis_tdata(d_sd), .s_axis_tkeep(d_sk),
    .s_axis_tlast(d_sl), .s_axis_tdest(d_sdst),
    .m_axis_tvalid(d_mv), .m_axis_tready(d_mr), .m_axis_tdata(d_md), .m_axis_tkeep(d_mk),
    .m_axis_tlast(d_ml), .m_axis_tdest(d_mdst), .pkt_count(d_cnt));

  axis_width_converter_gen #(.S_WIDTH(64), .M_WIDTH(64), .DEST_WIDTH(1)) u_eq (
    .net_clk(clk), .net_rst(rst),
    .s_axis_tvalid(e_sv), .s_axis_tready(e_sr), .s_axis_tdata(e_sd), .s_axis_tkeep(e_sk),
    .s_axis_tlast(e_sl), .s_axis_tdest(e_sdst),
    .m_axis_tvalid(e_mv), .m_axis_tready(e_mr), .m_axis_tdata(e_md), .m_axis_tkeep(e_mk),
    .m_axis_tlast(e_ml), .m_axis_tdest(e_mdst), .pkt_count(e_cnt));

  beat_t u_pend[$], u_exp[$], d_exp[$], e_exp[$];
  int u_pk = 0, d_pk = 0, e_pk = 0, e_nlast = 0, d_acc_cyc = 0;
  int d_beat_cyc[$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] kmask(input logic [63:0] k);
    logic [511:0] m;
    for (int i = 0; i < 64; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic logic [63:0] ckeep(input int n);
    return (n >= 64) ? '1 : (64'd1 << n) - 64'd1;
  endfunction

  // Narrow beats produced by one wide beat: all 8 unless tlast, then up to the last non-empty lane.
  function automatic int dn_lanes(input logic [63:0] kp, input logic ls);
    int n;
    if (!ls) return 8;
    n = 1;
    for (int i = 0; i < 8; i++) if (kp[i*8 +: 8] != 8'h00) n = i + 1;
    return n;
  endfunction

  // Ready generators.
  always @(posedge clk) begin
    #1;
    u_mr = (u_rm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    d_mr = (d_rm == 0) ? 1'b1 : (d_rm == 2) ? ~d_mr : 1'($urandom_range(0, 1));
    e_mr = (e_rm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Output monitors: every accepted beat is compared with the model queue head.
  always @(negedge clk) begin : mon_up
    beat_t e;
    if (!rst && u_mv && u_mr) begin
      if (u_exp.size() == 0) check("up_extra_beat", 512'(1), 512'(0));
      else begin
        e = u_exp.pop_front();
        check("up_keep", 512'(u_mk), 512'(e.keep));
        check("up_data", u_md & kmask(e.keep), e.data & kmask(e.keep));
        check("up_last", 512'(u_ml), 512'(e.last));
        check("up_dest", 512'(u_mdst), 512'(e.dest));
        if (e.last) u_pk++;
      end
    end
  end

  always @(negedge clk) begin : mon_dn
    beat_t e;
    if (!rst && d_mv && !d_mr && d_exp.size() != 0)
      check("dn_stall_data", 512'(d_md), d_exp[0].data);
    if (!rst && d_mv && d_mr) begin
      d_beat_cyc.push_back(cyc);
      if (d_exp.size() == 0) check("dn_extra_beat", 512'(1), 512'(0));
      else begin
        e = d_exp.pop_front();
        check("dn_keep", 512'(d_mk), 512'(e.keep));
        check("dn_data", 512'(d_md), e.data);
        check("dn_last", 512'(d_ml), 512'(e.last));
        check("dn_dest", 512'(d_mdst), 512'(e.dest));
        if (e.last) d_pk++;
      end
    end
  end

  always @(negedge clk) begin : mon_eq
    beat_t e;
    if (!rst && e_mv && e_mr) begin
      if (e_exp.size() == 0) check("eq_extra_beat", 512'(1), 512'(0));
      else begin
        e = e_exp.pop_front();
        check("eq_beat", {e_md, e_mk, e_ml, e_mdst}, {e.data[63:0], e.keep[7:0], e.last, e.dest});
        if (e.last) e_pk++;
      end
    end
  end

  task automatic up_send(input logic [63:0] dt, input logic [7:0] kp, input logic ls, input logic ds);
    int t;
    beat_t b, w;
    u_sv = 1'b1; u_sd = dt; u_sk = kp; u_sl = ls; u_sdst = ds; t = 0;
    @(negedge clk);
    while (!u_sr && t < 500) begin @(negedge clk); t++; end
    if (!u_sr) check("up_accept_timeout", 512'(u_sr), 512'(1));
    else begin
      b = '{data: 512'(dt), keep: 64'(kp), last: ls, dest: ds};
      u_pend.push_back(b);
      if (ls || u_pend.size() == 8) begin
        w = '0;
        for (int i = 0; i < u_pend.size(); i++) begin
          w.data[i*64 +: 64] = u_pend[i].data[63:0];
          w.keep[i*8 +: 8]   = u_pend[i].keep[7:0];
        end
        w.last = ls;
        w.dest = u_pend[0].dest;
        u_exp.push_back(w);
        u_pend.delete();
      end
    end
    @(posedge clk); #1;
    u_sv = 1'b0;
  endtask

  task automatic dn_send(input logic [511:0] dt, input logic [63:0] kp, input logic ls, input logic ds);
    int t, n;
    d_sv = 1'b1; d_sd = dt; d_sk = kp; d_sl = ls; d_sdst = ds; t = 0;
    @(negedge clk);
    while (!d_sr && t < 500) begin @(negedge clk); t++; end
    if (!d_sr) check("dn_accept_timeout", 512'(d_sr), 512'(1));
    else begin
      d_acc_cyc = cyc;
      n = dn_lanes(kp, ls);
      for (int i = 0; i < n; i++)
        d_exp.push_back('{data: 512'(dt[i*64 +: 64]), keep: 64'(kp[i*8 +: 8]),
                          last: ls && (i == n - 1), dest: ds});
    end
    @(posedge clk); #1;
    d_sv = 1'b0;
  endtask

  task automatic eq_send(input logic [63:0] dt, input logic [7:0] kp, input logic ls, input logic ds);
    int t;
    e_sv = 1'b1; e_sd = dt; e_sk = kp; e_sl = ls; e_sdst = ds; t = 0;
    @(negedge clk);
    while (!e_sr && t < 500) begin @(negedge clk); t++; end
    if (!e_sr) check("eq_accept_timeout", 512'(e_sr), 512'(1));
    else begin
      e_exp.push_back('{data: 512'(dt), keep: 64'(kp), last: ls, dest: ds});
      if (ls) e_nlast++;
    end
    @(posedge clk); #1;
    e_sv = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((u_exp.size() + d_exp.size() + e_exp.size()) != 0 && t < 3000) begin
      @(posedge clk); t++;
    end
    if ((u_exp.size() + d_exp.size() + e_exp.size()) != 0)
      check("drain_timeout", 512'(u_exp.size() + d_exp.size() + e_exp.size()), 512'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_up_sready", 512'(u_sr), 512'(0));
    check("rst_dn_sready", 512'(d_sr), 512'(0));
    check("rst_eq_sready", 512'(e_sr), 512'(0));
    check("rst_up_out", {u_mv, u_md, u_mk, u_ml, u_mdst}, '0);
    check("rst_dn_out", {d_mv, d_md, d_mk, d_ml, d_mdst}, '0);
    check("rst_eq_out", {e_mv, e_md, e_mk, e_ml, e_mdst}, '0);
    check("rst_cnt", {u_cnt, d_cnt, e_cnt}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Upsize: full 8-beat packet, output valid right after the completing beat.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("up_early_valid", 512'(u_mv), 512'(0));
      up_send(64'(i), 8'hFF, i == 7, 1'b0);
    end
    check("up_latency_valid", 512'(u_mv), 512'(1));
    drain();
    check("up_cnt_1", 512'(u_cnt), 512'(1));

    // Upsize: short 3-beat packet with partial last keep, dest 1.
    up_send(64'hA0A0, 8'hFF, 1'b0, 1'b1);
    up_send(64'hB1B1, 8'hFF, 1'b0, 1'b1);
    up_send(64'hC2C2, 8'h0F, 1'b1, 1'b1);
    check("up_short_keep", 512'(u_mk), 512'(64'h0000_0000_000F_FFFF));
    drain();
    check("up_cnt_2", 512'(u_cnt), 512'(2));

    // Upsize: random packets under random backpressure.
    u_rm = 1;
    for (int p = 0; p < 25; p++) begin
      int len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        logic ls = (b == len - 1);
        up_send({$urandom, $urandom}, ls ? 8'(ckeep($urandom_range(0, 8))) : 8'hFF, ls,
                1'($urandom_range(0, 1)));
      end
    end
    drain();
    u_rm = 0;
    check("up_cnt_rand", 512'(u_cnt), 512'(u_pk));

    // Downsize: two 3-lane tlast words back to back -> 6 consecutive beats.
    d_beat_cyc.delete();
    dn_send({16{$urandom}}, 64'h0000_0000_00FF_FFFF, 1'b1, 1'b0);
    dn_send({16{$urandom}}, 64'h0000_0000_00FF_FFFF, 1'b1, 1'b1);
    drain();
    check("dn_b2b_beats", 512'(d_beat_cyc.size()), 512'(6));
    if (d_beat_cyc.size() == 6) check("dn_b2b_span", 512'(d_beat_cyc[5] - d_beat_cyc[0]), 512'(5));
    check("dn_cnt_2", 512'(d_cnt), 512'(2));

    // Downsize: two full words under 1010 ready; second word waits for the final lane.
    d_rm = 2;
    d_beat_cyc.delete();
    dn_send({16{$urandom}}, '1, 1'b0, 1'b0);
    dn_send({16{$urandom}}, '1, 1'b1, 1'b0);
    drain();
    check("dn_tog_beats", 512'(d_beat_cyc.size()), 512'(16));
    if (d_beat_cyc.size() == 16) check("dn_tog_sready", 512'(d_acc_cyc), 512'(d_beat_cyc[7]));
    d_rm = 0;

    // Downsize: empty tlast beat and a non-last beat with empty upper lanes.
    dn_send({16{$urandom}}, 64'h0, 1'b1, 1'b1);
    dn_send({16{$urandom}}, 64'h0000_0000_0000_0FFF, 1'b0, 1'b0);
    dn_send({16{$urandom}}, '1, 1'b1, 1'b0);
    drain();

    // Downsize: random words under random backpressure.
    d_rm = 1;
    for (int w = 0; w < 30; w++) begin
      logic ls = ($urandom_range(0, 2) == 0);
      dn_send({16{$urandom}},
              ls ? ckeep($urandom_range(0, 64)) :
                   (($urandom_range(0, 3) == 0) ? ckeep($urandom_range(0, 63)) : '1),
              ls, 1'($urandom_range(0, 1)));
    end
    drain();
    d_rm = 0;
    check("dn_cnt_rand", 512'(d_cnt), 512'(d_pk));

    // Equal: 1000 beats with random gaps and random ready.
    e_rm = 1;
    for (int i = 0; i < 1000; i++) begin
      logic ls = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      eq_send({$urandom, $urandom}, ls ? 8'(ckeep($urandom_range(0, 8))) : 8'hFF, ls,
              1'($urandom_range(0, 1)));
    end
    drain();
    e_rm = 0;
    check("eq_cnt", 512'(e_cnt), 512'(e_nlast));

    // Reset in the middle of an upsize packet, then a fresh packet.
    for (int i = 0; i < 4; i++) up_send(64'(100 + i), 8'hFF, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_up_sready", 512'(u_sr), 512'(0));
    check("mid_rst_dn_sready", 512'(d_sr), 512'(0));
    u_pend.delete();
    u_pk = 0; d_pk = 0; e_pk = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_cnt", {u_cnt, d_cnt, e_cnt}, '0);
    check("mid_rst_up_valid", 512'(u_mv), 512'(0));
    for (int i = 0; i < 8; i++) up_send(64'(200 + i), 8'hFF, i == 7, 1'b0);
    drain();
    check("post_rst_cnt", 512'(u_cnt), 512'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_width_converter_gen.md
Name: axis_width_converter_gen

Overview:
- Parametrised AXI4-Stream data-width converter with TDEST, successor to the fixed 64<->512 converters on the RoCE memory and TX data paths.
- One module covers three modes, selected at elaboration from S_WIDTH and M_WIDTH:
  - upsize (narrow to wide)
  - downsize (wide to narrow)
  - equal width (register slice)
- Adds keep-aware packet trimming on downsize, per-word TDEST capture, and a packet counter.
- Sits between rocev2_ip and the DMA/role streams in net_clk.

Parameters:
S_WIDTH, 64, input data width in bits; multiple of 8.
M_WIDTH, 512, output data width in bits; multiple of 8. max(S,M)/min(S,M) must be a power of two, 1..64.
DEST_WIDTH, 1, TDEST width in bits; minimum 1.
- Derived value: R = max(S_WIDTH,M_WIDTH)/min(S_WIDTH,M_WIDTH).
- Derived value: LB = min(S_WIDTH,M_WIDTH)/8 (bytes per lane).
- Elaboration fails if the ratio is not a power of two.

Ports:
net_clk  in  1  clock
net_rst  in  1  reset, synchronous, active-high
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input ready
s_axis_tdata  in  S_WIDTH  input data
s_axis_tkeep  in  S_WIDTH/8  input byte enables; contiguous from bit 0
s_axis_tlast  in  1  input end of packet
s_axis_tdest  in  DEST_WIDTH  input destination
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  output ready
m_axis_tdata  out  M_WIDTH  output data
m_axis_tkeep  out  M_WIDTH/8  output byte enables
m_axis_tlast  out  1  output end of packet
m_axis_tdest  out  DEST_WIDTH  output destination
pkt_count  out  32  output packets completed (beats with m_tvalid, m_tready and m_tlast all high); wraps at 2^32-1 to 0

Behaviour:
Reset and general rules:
- On net_rst high at a clock edge, the following registers clear:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tdest=0
  - pkt_count=0
  - lane index=0, accumulator=0, wide buffer empty
- s_axis_tready=0 while net_rst is high.
- Reset mid-packet discards partial data. The first beat after reset starts a new word.
- All outputs are registered. There is no combinational path from s_axis_tvalid to m_axis_tvalid.
- Handshake: a transfer occurs when valid and ready are both high. Once valid is asserted, data, keep, last and dest stay stable until the transfer completes.

Equal mode (R=1, S=M):
- Single-entry register slice: s_axis_tready = !m_axis_tvalid || m_axis_tready.
- Latency 1 cycle; full throughput.

Upsize mode (M>S):
- Accumulator of R lanes; lane index idx counts 0..R-1.
- Each accepted beat writes data and keep to lane idx.
- TDEST is captured from the beat with idx=0.
- Word completes when idx=R-1 or s_axis_tlast=1. On completion:
  - word moves to the output register
  - keep of unwritten lanes is forced to 0
  - m_axis_tlast = s_axis_tlast
  - idx resets to 0
- s_axis_tready = !m_axis_tvalid || m_axis_tready. Accumulation stalls while an unaccepted output word is held.
- m_axis_tvalid rises the cycle after the completing input beat.
- Throughput: 1 input beat per cycle when m_axis_tready=1.

Downsize mode (S>M):
- One wide buffer, with an emit index k counting 0..R-1.
- s_axis_tready = buffer empty OR (final narrow beat being accepted this cycle). This gives back-to-back words with no bubble.
- The first narrow beat (lane 0) is valid the cycle after the wide beat is accepted.
- Lane k of the buffer drives tdata/tkeep. TDEST comes from the buffered wide beat.
- Final lane of a word is k=R-1, or, when the buffered beat had tlast=1, the highest lane with nonzero keep.
  - Trailing lanes with all-zero keep are never emitted.
  - m_axis_tlast=1 only on the final lane of a tlast word.
- A tlast beat with all-zero tkeep emits exactly one narrow beat with keep=0 and last=1.
- Zero-keep lanes in a non-last beat are emitted unchanged.

Counter:
- pkt_count increments by 1 per output beat accepted with m_axis_tlast=1.
- It is a registered value; the increment is visible the cycle after the accepting edge.

Test Plan:
- Upsize S=64/M=512, 8 beats, data 0x0..0x7, keep 0xFF, last on beat 7, m_tready=1 -> one beat: data lanes 0..7 = 0..7, keep all-ones, last=1, valid 1 cycle after beat 7; pkt_count=1.
- Upsize 3-beat packet, last keep 0x0F, dest=1 -> one beat, keep=0x00000000000FFFFF, last=1, dest=1; next packet starts at lane 0.
- Downsize S=512/M=64, keep=0x0000000000FFFFFF, last=1 -> exactly 3 beats, keep 0xFF each, last only on beat 3; two such words back-to-back -> 6 beats in 6 consecutive cycles.
- Downsize, m_tready toggling 1010..., two full 512-bit words -> 16 beats in order, data stable while stalled, s_tready low until the final beat of word 1.
- Equal mode 64/64 with random valid/ready over 1000 beats -> output sequence identical to input; pkt_count equals the number of tlast beats.
- Reset asserted after 4 of 8 upsize beats, then a fresh 8-beat packet -> single output word containing only the new packet data; pkt_count counts from 0.
